// File: rtl/jtpopeye_pkg.sv
// Shared helpers for the Popeye video mixer.
//   pw_of(layers)              : bits needed to name one layer (at least 1)
//   identity_order(layers, pw) : packed priority order with slot i = layer i,
//                                slot 0 in the LSBs, sized for the largest mixer
package jtpopeye_pkg;

  localparam int MAX_LAYERS = 8;
  localparam int MAX_PW     = 3;
  localparam int ORDER_W    = MAX_LAYERS * MAX_PW;

  function automatic int pw_of(input int layers);
    return (layers < 2) ? 1 : $clog2(layers);
  endfunction

  function automatic logic [ORDER_W-1:0] identity_order(input int layers, input int pw);
    logic [ORDER_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      if (i < layers) r = r | (ORDER_W'(i) << (i * pw));
    end
    return r;
  endfunction

endpackage

// File: rtl/jtpopeye_pal_ram.sv
// One palette bank: 2^aw x dw, written from the programming port on any
// clk, read synchronously when cen is high. A read and a write of the same
// entry in one cycle return the old contents.
//   clk, cen       : clock and read enable
//   we, wr_addr, din : write port
//   rd_addr, q     : registered read port
//   simfile        : name of a preload image for simulation wrappers; the
//                    contents normally arrive through the write port
module jtpopeye_pal_ram #(
  parameter int    aw      = 6,
  parameter int    dw      = 8,
  parameter string simfile = ""
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic [aw-1:0] wr_addr,
  input  logic [dw-1:0] din,
  input  logic [aw-1:0] rd_addr,
  output logic [dw-1:0] q
);

  logic [dw-1:0] mem [2**aw];

  // Contents are deliberately not reset: the CPU programs them once.
  always_ff @(posedge clk) begin
    if (we)  mem[wr_addr] <= din;
    if (cen) q <= mem[rd_addr];
  end

  if (simfile != "") begin : g_simfile
  end

endmodule

// File: rtl/jtpopeye_prio_mix.sv
// Layer priority mixer. Each layer looks its colour index up in its own
// palette, the highest-priority valid layer wins and its (optionally
// inverted) palette word drives RGB. Blanking is delayed alongside.
//   clk, rst, pxl_cen          : clock, sync reset, pixel enable
//   prog_we/layer/addr/din     : palette programming (any clk)
//   prio_we, prio_din          : next priority order, applied at vblank start
//   HBD_n, VB_n                : active-low blanking inputs
//   lyr_col, lyr_vld           : per-layer colour index and pixel valid
//   red/green/blue, *_dly      : mixed colour and aligned blanking
// Pipeline: S1 palette read + input latch, S2 select (comb), S3 register.
module jtpopeye_prio_mix
  import jtpopeye_pkg::*;
#(
  parameter int LAYERS   = 4,
  parameter int CW       = 6,
  parameter int RW       = 3,
  parameter int GW       = 3,
  parameter int BW       = 2,
  parameter bit INVERT   = 1,
  parameter bit BG_SOLID = 1,
  localparam int PW = pw_of(LAYERS),
  localparam int DW = RW + GW + BW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pxl_cen,
  input  logic                 prog_we,
  input  logic [PW-1:0]        prog_layer,
  input  logic [CW-1:0]        prog_addr,
  input  logic [DW-1:0]        prog_din,
  input  logic                 prio_we,
  input  logic [LAYERS*PW-1:0] prio_din,
  input  logic                 HBD_n,
  input  logic                 VB_n,
  input  logic [LAYERS*CW-1:0] lyr_col,
  input  logic [LAYERS-1:0]    lyr_vld,
  output logic [RW-1:0]        red,
  output logic [GW-1:0]        green,
  output logic [BW-1:0]        blue,
  output logic                 HBD_n_dly,
  output logic                 VB_n_dly
);

  localparam logic [ORDER_W-1:0]   ID_FULL  = identity_order(LAYERS, PW);
  localparam logic [LAYERS*PW-1:0] ID_ORDER = ID_FULL[LAYERS*PW-1:0];

  logic [DW-1:0]        pal_q [LAYERS];
  logic [LAYERS*PW-1:0] prio_pend, prio_act;
  logic                 vb_last;
  logic [LAYERS-1:0]    vld1;
  logic                 hb1, vb1;
  logic [PW-1:0]        slot_lyr;
  logic                 sel_hit;
  logic [DW-1:0]        sel_col;
  logic [DW-1:0]        rgb;

  // S1: palette banks, one per layer
  for (genvar i = 0; i < LAYERS; i++) begin : g_pal
    jtpopeye_pal_ram #(.aw(CW), .dw(DW), .simfile("")) u_pal (
      .clk     (clk),
      .cen     (pxl_cen),
      .we      (prog_we && (prog_layer == PW'(i))),
      .wr_addr (prog_addr),
      .din     (prog_din),
      .rd_addr (lyr_col[i*CW +: CW]),
      .q       (pal_q[i])
    );
  end

  // Priority order: the CPU may rewrite the pending copy at any time, the
  // active copy only changes on the pixel where VB_n goes from high to low,
  // so a frame is always drawn with a single order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_pend <= ID_ORDER;
      prio_act  <= ID_ORDER;
      vb_last   <= 1'b1;
    end else begin
      if (prio_we) prio_pend <= prio_din;
      if (pxl_cen) begin
        vb_last <= VB_n;
        if (vb_last && !VB_n) prio_act <= prio_pend;
      end
    end
  end

  // S1: latch valids and blanking alongside the palette read
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1 <= '0;
      hb1  <= 1'b0;
      vb1  <= 1'b0;
    end else if (pxl_cen) begin
      vld1 <= lyr_vld;
      hb1  <= HBD_n;
      vb1  <= VB_n;
    end
  end

  // S2: walk from the lowest priority slot upwards so the last eligible
  // slot seen (the lowest-numbered one) wins; duplicates resolve the same way.
  always_comb begin
    sel_hit  = 1'b0;
    sel_col  = '0;
    slot_lyr = '0;
    for (int s = LAYERS - 1; s >= 0; s--) begin
      slot_lyr = prio_act[s*PW +: PW];
      if (int'(slot_lyr) < LAYERS) begin
        if (vld1[slot_lyr] || (BG_SOLID && (s == LAYERS - 1))) begin
          sel_hit = 1'b1;
          sel_col = pal_q[slot_lyr];
        end
      end
    end
  end

  // S3: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= '0;
      HBD_n_dly <= 1'b0;
      VB_n_dly  <= 1'b0;
    end else if (pxl_cen) begin
      HBD_n_dly <= hb1;
      VB_n_dly  <= vb1;
      if (sel_hit && hb1 && vb1) rgb <= INVERT ? ~sel_col : sel_col;
      else                       rgb <= '0;
    end
  end

  // Palette word is {blue, green, red}, MSB to LSB
  assign red   = rgb[RW-1:0];
  assign green = rgb[RW +: GW];
  assign blue  = rgb[RW+GW +: BW];

endmodule

// File: tb/tb_jtpopeye_prio_mix.sv
module tb_jtpopeye_prio_mix;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        prog_we = 1'b0;
  logic [1:0]  prog_layer = '0;
  logic [5:0]  prog_addr = '0;
  logic [7:0]  prog_din = '0;
  logic        prio_we = 1'b0;
  logic [7:0]  prio_din = '0;
  logic        HBD_n = 1'b0;
  logic        VB_n = 1'b0;
  logic [23:0] lyr_col = '0;
  logic [3:0]  lyr_vld = '0;

  logic [2:0] red1, green1, red0, green0;
  logic [1:0] blue1, blue0;
  logic       hb_dly1, vb_dly1, hb_dly0, vb_dly0;
  logic [9:0] got1, got0;

  assign got1 = {vb_dly1, hb_dly1, blue1, green1, red1};
  assign got0 = {vb_dly0, hb_dly0, blue0, green0, red0};

  jtpopeye_prio_mix #(.BG_SOLID(1)) dut1 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .prog_we(prog_we), .prog_layer(prog_layer), .prog_addr(prog_addr), .prog_din(prog_din),
    .prio_we(prio_we), .prio_din(prio_din), .HBD_n(HBD_n), .VB_n(VB_n),
    .lyr_col(lyr_col), .lyr_vld(lyr_vld),
    .red(red1), .green(green1), .blue(blue1), .HBD_n_dly(hb_dly1), .VB_n_dly(vb_dly1)
  );

  jtpopeye_prio_mix #(.BG_SOLID(0)) dut0 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .prog_we(prog_we), .prog_layer(prog_layer), .prog_addr(prog_addr), .prog_din(prog_din),
    .prio_we(prio_we), .prio_din(prio_din), .HBD_n(HBD_n), .VB_n(VB_n),
    .lyr_col(lyr_col), .lyr_vld(lyr_vld),
    .red(red0), .green(green0), .blue(blue0), .HBD_n_dly(hb_dly0), .VB_n_dly(vb_dly0)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: palette contents, pending/active order, vblank history
  logic [7:0]  pal_m [4][64];
  logic [1:0]  pend_m [4];
  logic [1:0]  act_m [4];
  bit          vb_prev;
  logic [19:0] exp_q [$];   // {bg_solid=0 expectation, bg_solid=1 expectation}
  logic [19:0] exp_v;
  int          checks = 0;
  int          failures = 0;

  // Colour shown for the current inputs: first slot (0 = highest) whose layer
  // is valid, or the last slot when the background is solid.
  function automatic logic [9:0] model_out(input bit bg);
    logic [1:0] l;
    if (HBD_n && VB_n) begin
      for (int s = 0; s < 4; s++) begin
        l = act_m[s];
        if (lyr_vld[l] || (bg && s == 3))
          return {VB_n, HBD_n, ~pal_m[l][lyr_col[l*6 +: 6]]};
      end
    end
    return {VB_n, HBD_n, 8'h00};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    pxl_cen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      pend_m[s] = 2'(s);
      act_m[s]  = 2'(s);
    end
    vb_prev = 1'b1;
    exp_q.delete();
    exp_q.push_back(20'h0);   // the reset pipeline drains as blanked black
  endtask

  // driver: one clk with the current inputs; the model sees the palette as it
  // was before this edge (read-before-write)
  task automatic tick();
    if (pxl_cen) begin
      if (vb_prev && !VB_n)
        for (int s = 0; s < 4; s++) act_m[s] = pend_m[s];
      vb_prev = VB_n;
      exp_q.push_back({model_out(1'b0), model_out(1'b1)});
    end
    if (prio_we)
      for (int s = 0; s < 4; s++) pend_m[s] = prio_din[2*s +: 2];
    if (prog_we) pal_m[prog_layer][prog_addr] = prog_din;
    @(posedge clk); #1;
    prog_we = 1'b0;
    prio_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (got1 !== 10'h0 || got0 !== 10'h0) begin
      failures++;
      $display("FAIL reset_state got=%h/%h exp=000/000", got1, got0);
    end
    // program every palette entry with pxl_cen low
    pxl_cen = 1'b0;
    for (int l = 0; l < 4; l++) begin
      for (int a = 0; a < 64; a++) begin
        prog_we = 1'b1; prog_layer = 2'(l); prog_addr = 6'(a); prog_din = 8'($urandom);
        tick();
      end
    end
    checks++;
    if (got1 !== 10'h0 || got0 !== 10'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h/%h exp=000/000", got1, got0);
    end
  endtask

  task automatic test_basic();
    prog_we = 1'b1; prog_layer = 2'd0; prog_addr = 6'd5; prog_din = 8'h1C;
    tick();
    lyr_vld = 4'b0001; lyr_col = {18'($urandom), 6'd5}; HBD_n = 1'b1; VB_n = 1'b1;
    pxl_cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // same-cycle write of the entry being read on the first cen
      if (i == 0) begin
        prog_we = 1'b1; prog_layer = 2'd0; prog_addr = 6'd5; prog_din = 8'h55;
      end
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL basic_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
      if (i == 1) begin
        checks++;
        if (got1[7:0] !== 8'hE3) begin
          failures++;
          $display("FAIL basic_e3 got=%h exp=e3", got1[7:0]);
        end
      end
      if (i == 2) begin
        checks++;
        if (got1[7:0] !== 8'hAA) begin
          failures++;
          $display("FAIL basic_rdw got=%h exp=aa", got1[7:0]);
        end
      end
    end
    pxl_cen = 1'b0;
  endtask

  task automatic test_prio_switch();
    lyr_vld = 4'hF; HBD_n = 1'b1; VB_n = 1'b1;
    pxl_cen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lyr_col = 24'($urandom);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL prio_pre_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
    end
    pxl_cen = 1'b0;
    prio_we = 1'b1; prio_din = 8'h1B;   // slot0=3, slot1=2, slot2=1, slot3=0
    tick();
    lyr_col = 24'($urandom);
    pxl_cen = 1'b1;
    for (int i = 0; i < 7; i++) begin
      VB_n = (i != 3);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL prio_sw_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
    end
    checks++;
    if (got1[7:0] !== ~pal_m[3][lyr_col[23:18]]) begin
      failures++;
      $display("FAIL prio_layer3 got=%h exp=%h", got1[7:0], ~pal_m[3][lyr_col[23:18]]);
    end
    pxl_cen = 1'b0;
  endtask

  task automatic test_bg();
    do_reset();
    lyr_vld = 4'h0; HBD_n = 1'b1; VB_n = 1'b1; lyr_col = 24'($urandom);
    pxl_cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL bg_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
    end
    checks++;
    if (got1[7:0] !== ~pal_m[3][lyr_col[23:18]] || got0[7:0] !== 8'h00) begin
      failures++;
      $display("FAIL bg_solid got=%h/%h exp=%h/00", got1[7:0], got0[7:0], ~pal_m[3][lyr_col[23:18]]);
    end
    pxl_cen = 1'b0;
  endtask

  task automatic test_vblank();
    lyr_vld = 4'hF; HBD_n = 1'b1; VB_n = 1'b0; lyr_col = 24'($urandom);
    pxl_cen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) VB_n = 1'b1;
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL vblank_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
      if (i == 2) begin
        checks++;
        if (got1 !== 10'b01_0000_0000) begin
          failures++;
          $display("FAIL vblank_black got=%h exp=100", got1);
        end
      end
    end
    pxl_cen = 1'b0;
  endtask

  task automatic test_cen_hold();
    logic [9:0]  held1, held0;
    logic [23:0] col_keep;
    logic [7:0]  new_data;
    col_keep = 24'($urandom);
    new_data = 8'($urandom);
    lyr_vld = 4'b0001; HBD_n = 1'b1; VB_n = 1'b1; lyr_col = col_keep;
    pxl_cen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL hold_pre_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
    end
    held1 = exp_v[9:0];
    held0 = exp_v[19:10];
    pxl_cen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lyr_vld = 4'($urandom); lyr_col = 24'($urandom);
      HBD_n = 1'($urandom); VB_n = 1'($urandom);
      if (i == 3) begin
        prog_we = 1'b1; prog_layer = 2'd0; prog_addr = col_keep[5:0]; prog_din = new_data;
      end
      tick();
      checks++;
      if (got1 !== held1 || got0 !== held0) begin
        failures++;
        $display("FAIL hold_frozen_%0d got=%h/%h exp=%h/%h", i, got1, got0, held1, held0);
      end
    end
    lyr_vld = 4'b0001; HBD_n = 1'b1; VB_n = 1'b1; lyr_col = col_keep;
    pxl_cen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL hold_post_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
    end
    checks++;
    if (got1[7:0] !== ~new_data) begin
      failures++;
      $display("FAIL hold_newdata got=%h exp=%h", got1[7:0], ~new_data);
    end
    pxl_cen = 1'b0;
  endtask

  task automatic test_rst_discard();
    pxl_cen = 1'b0;
    prio_we = 1'b1; prio_din = 8'h1B;
    tick();
    do_reset();
    lyr_vld = 4'hF; HBD_n = 1'b1; lyr_col = 24'($urandom);
    pxl_cen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      VB_n = (i != 1);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
        failures++;
        $display("FAIL rstd_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
      end
    end
    checks++;
    if (got1[7:0] !== ~pal_m[0][lyr_col[5:0]]) begin
      failures++;
      $display("FAIL rstd_identity got=%h exp=%h", got1[7:0], ~pal_m[0][lyr_col[5:0]]);
    end
    pxl_cen = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      pxl_cen = 1'($urandom_range(0, 1));
      lyr_vld = 4'($urandom);
      lyr_col = 24'($urandom);
      HBD_n   = ($urandom_range(0, 7) != 0);
      VB_n    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) begin
        prog_we = 1'b1; prog_layer = 2'($urandom); prog_addr = 6'($urandom); prog_din = 8'($urandom);
      end
      if ($urandom_range(0, 31) == 0) begin
        prio_we = 1'b1; prio_din = 8'($urandom);
      end
      tick();
      if (pxl_cen) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (got1 !== exp_v[9:0] || got0 !== exp_v[19:10]) begin
          failures++;
          $display("FAIL random_%0d got=%h/%h exp=%h/%h", i, got1, got0, exp_v[9:0], exp_v[19:10]);
        end
      end
    end
    pxl_cen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prio_switch();
    test_bg();
    test_vblank();
    test_cen_hold();
    test_rst_discard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
